// File: rtl/edc_pkg.sv
// Shared SEC-DED definitions for the cache scrubber: code geometry, the
// Hamming position table, the store-path encoder and the scrubber state set.
package edc_pkg;

    localparam int DATA_W = 32;
    localparam int PAR_W  = 7;
    localparam int CHK_W  = 6;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_READ,
        ST_CHECK,
        ST_FIX,
        ST_NEXT
    } scrub_state_e;

    typedef logic [CHK_W-1:0] pos_t;

    // Codeword position (1..38) of each data bit; powers of two hold check bits.
    localparam pos_t DATA_POS [DATA_W] = '{
        6'd3,  6'd5,  6'd6,  6'd7,  6'd9,  6'd10, 6'd11, 6'd12,
        6'd13, 6'd14, 6'd15, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21,
        6'd22, 6'd23, 6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
        6'd30, 6'd31, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38
    };

    // Check bit k covers every data position with bit k set, so the check
    // vector is simply the XOR of the positions of all set data bits.
    function automatic logic [CHK_W-1:0] secded_check(input logic [DATA_W-1:0] data);
        logic [CHK_W-1:0] chk;
        chk = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (data[i]) chk = chk ^ DATA_POS[i];
        end
        return chk;
    endfunction

    function automatic logic [PAR_W-1:0] secded_encode(input logic [DATA_W-1:0] data);
        logic [CHK_W-1:0] chk;
        chk = secded_check(data);
        return {(^data) ^ (^chk), chk};
    endfunction

endpackage

// File: rtl/edc_scrubber_if.sv
// Cache-array side of the scrubber: asynchronous read port plus the
// error_* write port that overrides the CPU path.
interface edc_scrubber_if
    import edc_pkg::*;
    #(parameter int ADDR_W = 9)
    ();

    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [PAR_W-1:0]  rd_parity;
    logic              error_dwe;
    logic              error_pwe;
    logic [ADDR_W-1:0] error_addr;
    logic [DATA_W-1:0] error_din;
    logic [PAR_W-1:0]  error_pin;

    modport master (
        output rd_addr, error_dwe, error_pwe, error_addr, error_din, error_pin,
        input  rd_data, rd_parity
    );

    modport slave (
        input  rd_addr, error_dwe, error_pwe, error_addr, error_din, error_pin,
        output rd_data, rd_parity
    );

endinterface

// File: rtl/secded_decoder.sv
// Combinational SEC-DED decoder: corrects a single flipped bit and flags
// words that cannot be corrected.
module secded_decoder
    import edc_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [PAR_W-1:0]  par,
    output logic [DATA_W-1:0] corrected,
    output logic              single_err,
    output logic              double_err
);

    logic [CHK_W-1:0] syndrome;
    logic             overall_bad;
    logic             pos_valid;

    always_comb begin
        syndrome    = secded_check(data) ^ par[CHK_W-1:0];
        overall_bad = ^{data, par};
        pos_valid   = (syndrome <= 6'd38);
        corrected   = data;
        // A syndrome of 0 or a power of two points at a check bit: data stays.
        for (int i = 0; i < DATA_W; i++) begin
            if (overall_bad && (syndrome == DATA_POS[i])) corrected[i] = ~data[i];
        end
        single_err = overall_bad && pos_valid;
        // Odd weight but a syndrome outside the codeword means 3+ flips.
        double_err = (!overall_bad && (syndrome != '0)) || (overall_bad && !pos_valid);
    end

endmodule

// File: rtl/edc_scrubber.sv
// Background SEC-DED scrubber: visits one cache word per idle interval,
// rewrites single-bit errors and reports uncorrectable words.
module edc_scrubber
    import edc_pkg::*;
    #(
        parameter int ADDR_W   = 9,
        parameter int INTERVAL = 1024,
        parameter int CNT_W    = 16
    )
(
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              cpu_busy,
    edc_scrubber_if.master    cache,
    output logic              ded_irq,
    output logic [ADDR_W-1:0] ded_addr,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  ded_cnt
);

    localparam int TMR_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    // WAIT hands over on the edge where the timer reaches INTERVAL-1, so the
    // last value actually held in WAIT is INTERVAL-2.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((INTERVAL >= 2) ? INTERVAL - 2 : 0);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    scrub_state_e      state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [ADDR_W-1:0] addr_ptr_q;
    logic              ded_irq_q;
    logic [ADDR_W-1:0] ded_addr_q;
    logic [CNT_W-1:0]  corr_cnt_q, ded_cnt_q;

    logic              capture, latch_fix, ded_hit, fix_hit, advance;
    logic [DATA_W-1:0] word_p0;
    logic [PAR_W-1:0]  par_p0;
    logic [DATA_W-1:0] fix_data_p1;
    logic [PAR_W-1:0]  fix_par_p1;
    logic [DATA_W-1:0] corrected;
    logic              single_err, double_err;
    logic              fix_on;

    secded_decoder u_dec (
        .data       (word_p0),
        .par        (par_p0),
        .corrected  (corrected),
        .single_err (single_err),
        .double_err (double_err)
    );

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        capture   = 1'b0;
        latch_fix = 1'b0;
        ded_hit   = 1'b0;
        fix_hit   = 1'b0;
        advance   = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (cpu_busy) begin
                    timer_d = '0;
                end else if (enable) begin
                    if (timer_q == TMR_LAST) begin
                        timer_d = '0;
                        state_d = ST_READ;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
            end
            ST_READ: begin
                if (!cpu_busy) begin
                    capture = 1'b1;
                    state_d = ST_CHECK;
                end else begin
                    timer_d = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_CHECK: begin
                if (single_err) begin
                    latch_fix = 1'b1;
                    // A CPU access now may have rewritten the word: re-read it.
                    state_d   = cpu_busy ? ST_READ : ST_FIX;
                end else begin
                    ded_hit = double_err;
                    state_d = ST_NEXT;
                end
            end
            ST_FIX: begin
                fix_hit = 1'b1;
                state_d = ST_NEXT;
            end
            ST_NEXT: begin
                advance = 1'b1;
                timer_d = '0;
                state_d = ST_WAIT;
            end
            default: state_d = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_WAIT;
            timer_q    <= '0;
            addr_ptr_q <= '0;
            ded_irq_q  <= 1'b0;
            ded_addr_q <= '0;
            corr_cnt_q <= '0;
            ded_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            ded_irq_q <= ded_hit;
            if (advance) addr_ptr_q <= addr_ptr_q + ADDR_W'(1);
            if (ded_hit) begin
                ded_addr_q <= addr_ptr_q;
                ded_cnt_q  <= sat_inc(ded_cnt_q);
            end
            if (fix_hit) corr_cnt_q <= sat_inc(corr_cnt_q);
        end
    end

    // p0: word captured from the arrays in READ; p1: corrected word and
    // re-encoded parity held for the FIX write.
    always_ff @(posedge clk) begin
        if (capture) begin
            word_p0 <= cache.rd_data;
            par_p0  <= cache.rd_parity;
        end
        if (latch_fix) begin
            fix_data_p1 <= corrected;
            fix_par_p1  <= secded_encode(corrected);
        end
    end

    // Strobes decode straight from the state so an async reset drops them at once.
    assign fix_on           = (state_q == ST_FIX);
    assign cache.rd_addr    = addr_ptr_q;
    assign cache.error_dwe  = fix_on;
    assign cache.error_pwe  = fix_on;
    assign cache.error_addr = fix_on ? addr_ptr_q  : '0;
    assign cache.error_din  = fix_on ? fix_data_p1 : '0;
    assign cache.error_pin  = fix_on ? fix_par_p1  : '0;

    assign ded_irq  = ded_irq_q;
    assign ded_addr = ded_addr_q;
    assign corr_cnt = corr_cnt_q;
    assign ded_cnt  = ded_cnt_q;

endmodule

// File: tb/tb_edc_scrubber.sv
// Randomized bench for edc_scrubber: a cache array model with injected
// errors, scored against a Hamming reference encoder and per-pass totals.
module tb_edc_scrubber;
    import edc_pkg::*;

    localparam int ADDR_W   = 9;
    localparam int INTERVAL = 4;
    localparam int CNT_W    = 3;
    localparam int CNT_MAX  = 7;
    localparam int WORDS    = 512;

    logic              clk = 1'b0;
    logic              rst, enable, cpu_busy;
    logic              ded_irq;
    logic [ADDR_W-1:0] ded_addr;
    logic [CNT_W-1:0]  corr_cnt, ded_cnt;

    edc_scrubber_if #(.ADDR_W(ADDR_W)) bus ();

    edc_scrubber #(.ADDR_W(ADDR_W), .INTERVAL(INTERVAL), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .cpu_busy (cpu_busy),
        .cache    (bus),
        .ded_irq  (ded_irq),
        .ded_addr (ded_addr),
        .corr_cnt (corr_cnt),
        .ded_cnt  (ded_cnt)
    );

    always #5 clk = ~clk;

    logic [31:0] mem_data [WORDS];
    logic [6:0]  mem_par  [WORDS];
    logic [31:0] golden   [WORDS];
    int          kind     [WORDS];   // 0 clean, 1 single pending, 2 uncorrectable

    assign bus.rd_data   = mem_data[bus.rd_addr];
    assign bus.rd_parity = mem_par[bus.rd_addr];

    int vectors = 0, miscompares = 0;
    int writes = 0, ded_pulses = 0;
    logic busy_d1 = 1'b0, busy_d2 = 1'b0;
    bit   busy_done;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Textbook Hamming: data fills non-power-of-two positions 1..38 in order.
    function automatic logic [6:0] ref_encode(input logic [31:0] d);
        logic [38:0] cw;
        logic [6:0]  p;
        int k;
        cw = '0; k = 0; p = '0;
        for (int pos = 1; pos <= 38; pos++)
            if ((pos & (pos - 1)) != 0) begin cw[pos] = d[k]; k++; end
        for (int b = 0; b < 6; b++)
            for (int pos = 1; pos <= 38; pos++)
                if (((pos >> b) & 1) == 1) p[b] = p[b] ^ cw[pos];
        p[6] = (^d) ^ (^p[5:0]);
        return p;
    endfunction

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    task automatic set_word(input int a, input logic [31:0] v);
        golden[a] = v; mem_data[a] = v; mem_par[a] = ref_encode(v); kind[a] = 0;
    endtask

    task automatic flip(input int a, input int b);
        if (b < 32) mem_data[a][b] = ~mem_data[a][b];
        else        mem_par[a][b-32] = ~mem_par[a][b-32];
    endtask

    task automatic inject(input int a, input int b1, input int b2);
        flip(a, b1);
        if (b2 >= 0) flip(a, b2);
        kind[a] = (b2 >= 0) ? 2 : 1;
    endtask

    task automatic inject_double_rand(input int a);
        int b1;
        b1 = $urandom_range(0, 37);
        inject(a, b1, $urandom_range(b1 + 1, 38));
    endtask

    // Cache array: scrubber write port lands on the clock edge.
    always @(posedge clk) begin
        if (bus.error_dwe) mem_data[bus.error_addr] = bus.error_din;
        if (bus.error_pwe) begin
            mem_par[bus.error_addr] = bus.error_pin;
            kind[bus.error_addr] = 0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (bus.error_dwe || bus.error_pwe) begin
                writes++;
                check("wr_dwe", bus.error_dwe, 1);
                check("wr_pwe", bus.error_pwe, 1);
                check("wr_idle_read_check", {busy_d2, busy_d1}, 0);
                check("wr_target_single", kind[bus.error_addr], 1);
                check("wr_din", bus.error_din, golden[bus.error_addr]);
                check("wr_pin", bus.error_pin, ref_encode(golden[bus.error_addr]));
            end
            if (ded_irq) begin
                ded_pulses++;
                check("ded_target", kind[ded_addr], 2);
            end
        end
        busy_d2 = busy_d1;
        busy_d1 = cpu_busy;
    end

    task automatic run_visits(input int n, input bit chk_period);
        logic [ADDR_W-1:0] prev, nxt;
        int cyc;
        for (int i = 0; i < n; i++) begin
            prev = bus.rd_addr; nxt = prev + 9'd1; cyc = 0;
            do begin @(posedge clk); #1; cyc++; end
            while (bus.rd_addr == prev && cyc < 2000);
            if (bus.rd_addr == prev) begin
                check("visit_timeout", cyc, 0);
                return;
            end
            check("visit_step", bus.rd_addr, nxt);
            if (chk_period && i > 0) check("visit_period", cyc, INTERVAL + 2);
        end
    endtask

    task automatic end_of_pass(input int exp_corr, input int exp_ded, input int exp_pulses,
                               input int exp_writes);
        int bad, pend, last;
        bad = 0; pend = 0; last = 0;
        for (int a = 0; a < WORDS; a++) begin
            if (kind[a] == 1) pend++;
            if (kind[a] == 2) last = a;
            if (kind[a] == 0 && (mem_data[a] !== golden[a] || mem_par[a] !== ref_encode(golden[a])))
                bad++;
        end
        check("pass_pending_singles", pend, 0);
        check("pass_unclean_words", bad, 0);
        check("pass_rd_addr_wrap", bus.rd_addr, 0);
        check("corr_cnt", corr_cnt, sat(exp_corr));
        check("ded_cnt", ded_cnt, sat(exp_ded));
        check("ded_pulses", ded_pulses, exp_pulses);
        check("writes", writes, exp_writes);
        if (exp_pulses > 0) check("ded_addr_last", ded_addr, last);
        ded_pulses = 0;
        writes = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n_ded;
        logic [31:0] bad_word;
        rst = 1'b1; enable = 1'b0; cpu_busy = 1'b0;
        for (int a = 0; a < WORDS; a++) set_word(a, $urandom);
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_addr", bus.rd_addr, 0);
        check("rst_dwe", bus.error_dwe, 0);
        check("rst_pwe", bus.error_pwe, 0);
        check("rst_err_addr", bus.error_addr, 0);
        check("rst_din", bus.error_din, 0);
        check("rst_pin", bus.error_pin, 0);
        check("rst_ded_irq", ded_irq, 0);
        check("rst_ded_addr", ded_addr, 0);
        check("rst_corr_cnt", corr_cnt, 0);
        check("rst_ded_cnt", ded_cnt, 0);

        // Clean array: full walk with fixed visit period and a wrap to 0.
        @(negedge clk); rst = 1'b1; enable = 1'b1;
        run_visits(WORDS, 1);
        end_of_pass(0, 0, 0, 0);

        // Disabled: scrubber parks and the pointer holds.
        @(posedge clk); #1 enable = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("park_rd_addr", bus.rd_addr, 0);
        check("park_writes", writes, 0);

        // Directed errors plus random singles and doubles.
        set_word('h010, 32'hDEADBEEF);
        inject('h010, 3, -1);
        inject('h020, 0, 7);
        inject('h030, $urandom_range(0, 38), -1);
        inject('h040, 38, -1);
        for (int k = 0; k < 6; k++) inject('h050 + k * 40 + $urandom_range(0, 39), $urandom_range(0, 38), -1);
        for (int k = 0; k < 3; k++) inject_double_rand('h140 + k * 30 + $urandom_range(0, 29));
        enable = 1'b1;
        fork
            run_visits(WORDS, 0);
            begin
                int cyc;
                cyc = 0;
                do begin @(posedge clk); #1; cyc++; end
                while (bus.rd_addr != 9'h030 && cyc < 5000);
                check("busy_wait_0x030", bus.rd_addr, 9'h030);
                repeat (4) @(posedge clk);
                #1 cpu_busy = 1'b1;
                @(negedge clk);
                check("busy_check_no_wr", bus.error_dwe, 0);
                @(posedge clk);
                #1 cpu_busy = 1'b0;
                @(negedge clk); check("reread_read_no_wr", bus.error_dwe, 0);
                @(negedge clk); check("reread_check_no_wr", bus.error_dwe, 0);
                @(negedge clk);
                check("reread_fix_dwe", bus.error_dwe, 1);
                check("reread_fix_addr", bus.error_addr, 9'h030);
            end
        join
        check("fix_0x010_data", mem_data['h010], 32'hDEADBEEF);
        check("fix_0x010_par", mem_par['h010], ref_encode(32'hDEADBEEF));
        check("fix_0x040_par", mem_par['h040], ref_encode(golden['h040]));
        check("ded_0x020_untouched", mem_data['h020], golden['h020] ^ 32'h0000_0081);
        end_of_pass(9, 4, 4, 9);

        // Random CPU traffic with a fresh batch of errors.
        for (int k = 0; k < 4; k++) inject('h1C0 + k * 16 + $urandom_range(0, 15), $urandom_range(0, 38), -1);
        inject_double_rand('h0A0 + $urandom_range(0, 15));
        busy_done = 1'b0;
        fork
            begin run_visits(WORDS, 0); busy_done = 1'b1; end
            begin
                while (!busy_done) begin @(posedge clk); #1 cpu_busy = ($urandom_range(0, 7) == 0); end
                cpu_busy = 1'b0;
            end
        join
        end_of_pass(13, 9, 5, 4);

        // Reset in the middle of a FIX write.
        n_ded = 5;
        inject('h005, $urandom_range(0, 31), -1);
        bad_word = mem_data['h005];
        begin
            int cyc;
            cyc = 0;
            do begin @(negedge clk); cyc++; end
            while (!bus.error_dwe && cyc < 500);
            check("rst_fix_reached", bus.error_dwe, 1);
        end
        #1 rst = 1'b0;
        #1;
        check("midfix_dwe", bus.error_dwe, 0);
        check("midfix_pwe", bus.error_pwe, 0);
        check("midfix_err_addr", bus.error_addr, 0);
        check("midfix_din", bus.error_din, 0);
        check("midfix_pin", bus.error_pin, 0);
        check("midfix_rd_addr", bus.rd_addr, 0);
        check("midfix_corr_cnt", corr_cnt, 0);
        check("midfix_ded_cnt", ded_cnt, 0);
        @(posedge clk);
        @(negedge clk); rst = 1'b1;
        check("midfix_word_kept", mem_data['h005], bad_word);
        writes = 0; ded_pulses = 0;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_rd_addr", bus.rd_addr, 0);
        check("post_rst_writes", writes, 0);
        run_visits(WORDS, 0);
        check("refix_0x005", mem_data['h005], golden['h005]);
        end_of_pass(1, n_ded, n_ded, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
